piezo_alert_gen: RTL and testbench

- Upstream stage of the piezo driver. Produces the three alert conditions `norm_mode`, `ovr_spd` and `batt_low` that the driver consumes.
- Sources:
  - battery samples from the A2D interface;
  - signed wheel speed commands from balance control;
  - the steering-enable and power-up state.
- Each output is filtered so that transient glitches do not chirp the piezo: hysteresis plus consecutive-sample qualification.

---
 rtl/piezo_alert_gen.sv | 131 +++++++++++++
 tb/tb_piezo_alert_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_alert_gen.sv
`default_nettype none
// piezo_alert_gen: hysteresis- and persistence-filtered norm_mode / ovr_spd / batt_low for the piezo driver.
// Revision 1.0 - initial release
module piezo_alert_gen #(
  parameter logic [11:0] BATT_LOW_TH = 12'h800,
  parameter logic [11:0] BATT_HYST   = 12'h040,
  parameter int          BATT_CNT    = 4,
  parameter logic [11:0] SPD_TH      = 12'd1536,
  parameter int          SPD_HOLD    = 1024,
  parameter int          NORM_QUAL   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic        en_steer,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic [11:0] batt,
  input  logic        batt_vld,
  output logic        norm_mode,
  output logic        ovr_spd,
  output logic        batt_low
);

  localparam int OCNT_W = $clog2(SPD_HOLD + 1);
  localparam int BCNT_W = $clog2(BATT_CNT + 1);
  localparam int NCNT_W = $clog2(NORM_QUAL + 1);
  localparam logic [12:0]       BATT_GOOD_TH = {1'b0, BATT_LOW_TH} + {1'b0, BATT_HYST};
  localparam logic [OCNT_W-1:0] OCNT_LAST    = OCNT_W'(SPD_HOLD - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST    = BCNT_W'(BATT_CNT - 1);
  localparam logic [NCNT_W-1:0] NCNT_MAX     = NCNT_W'(NORM_QUAL);

  // -2048 has no positive 12-bit counterpart, so it saturates to 2047
  function automatic logic [11:0] spd_mag(input logic [11:0] v);
    if (v == 12'h800)
      spd_mag = 12'h7FF;
    else if (v[11])
      spd_mag = ~v + 12'd1;
    else
      spd_mag = v;
  endfunction

  logic              ovr_cond;
  logic [OCNT_W-1:0] ocnt;

  assign ovr_cond = (spd_mag(lft_spd) > SPD_TH) || (spd_mag(rght_spd) > SPD_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocnt    <= '0;
      ovr_spd <= 1'b0;
    end else if (ovr_cond != ovr_spd) begin
      if (ocnt == OCNT_LAST) begin
        ovr_spd <= ~ovr_spd;
        ocnt    <= '0;
      end else begin
        ocnt <= ocnt + 1'b1;
      end
    end else begin
      ocnt <= '0;
    end
  end

  typedef enum logic [0:0] {
    BATT_OK  = 1'b0,
    BATT_LOW = 1'b1
  } batt_state_t;

  batt_state_t       bstate, bstate_nxt;
  logic [BCNT_W-1:0] bcnt, bcnt_nxt;
  logic              bqual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bstate   <= BATT_OK;
      bcnt     <= '0;
      batt_low <= 1'b0;
    end else begin
      bstate   <= bstate_nxt;
      bcnt     <= bcnt_nxt;
      batt_low <= (bstate_nxt == BATT_LOW);
    end
  end

  // A qualifying sample is one that argues for leaving the current state
  always_comb begin
    bstate_nxt = bstate;
    bcnt_nxt   = bcnt;
    bqual      = 1'b0;
    if (batt_vld) begin
      case (bstate)
        BATT_OK:  bqual = (batt < BATT_LOW_TH);
        BATT_LOW: bqual = ({1'b0, batt} >= BATT_GOOD_TH);
        default:  bqual = 1'b0;
      endcase
      if (!bqual) begin
        bcnt_nxt = '0;
      end else if (bcnt == BCNT_LAST) begin
        bcnt_nxt = '0;
        case (bstate)
          BATT_OK:  bstate_nxt = BATT_LOW;
          BATT_LOW: bstate_nxt = BATT_OK;
          default:  bstate_nxt = BATT_OK;
        endcase
      end else begin
        bcnt_nxt = bcnt + 1'b1;
      end
    end
  end

  logic              nqual;
  logic [NCNT_W-1:0] ncnt;

  assign nqual = en_steer && pwr_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncnt      <= '0;
      norm_mode <= 1'b0;
    end else if (!nqual) begin
      ncnt      <= '0;
      norm_mode <= 1'b0;
    end else begin
      norm_mode <= (ncnt == NCNT_MAX);
      if (ncnt != NCNT_MAX)
        ncnt <= ncnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piezo_alert_gen.sv
`default_nettype none
// tb_piezo_alert_gen: table-driven battery vectors, directed corner sequences and a randomized phase
// checked every cycle against a behavioural run-length model of the three alerts.
module tb_piezo_alert_gen;

  localparam int          SPD_HOLD  = 1024;
  localparam int          NORM_QUAL = 16;
  localparam int          BATT_CNT  = 4;
  localparam int          SPD_TH    = 1536;
  localparam int          BATT_TH   = 'h800;
  localparam int          BATT_GOOD = 'h840;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwr_up, en_steer, batt_vld;
  logic [11:0] lft_spd, rght_spd, batt;
  logic        norm_mode, ovr_spd, batt_low;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  piezo_alert_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwr_up   (pwr_up),
    .en_steer (en_steer),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .batt     (batt),
    .batt_vld (batt_vld),
    .norm_mode(norm_mode),
    .ovr_spd  (ovr_spd),
    .batt_low (batt_low)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; directed checks are made there too.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int mag(input logic [11:0] v);
    int s;
    s = $signed(v);
    if (s < 0) s = -s;
    if (s > 2047) s = 2047;
    return s;
  endfunction

  logic m_ovr, m_blow, m_norm;
  int   m_mis, m_brun, m_qrun;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ovr <= 1'b0; m_blow <= 1'b0; m_norm <= 1'b0;
      m_mis <= 0;    m_brun <= 0;    m_qrun <= 0;
    end else begin
      // output flips once the opposite condition has persisted SPD_HOLD consecutive cycles
      if ((mag(lft_spd) > SPD_TH || mag(rght_spd) > SPD_TH) != m_ovr) begin
        if (m_mis + 1 == SPD_HOLD) begin m_ovr <= !m_ovr; m_mis <= 0; end
        else m_mis <= m_mis + 1;
      end else begin
        m_mis <= 0;
      end
      if (batt_vld) begin
        if (m_blow ? (int'(batt) >= BATT_GOOD) : (int'(batt) < BATT_TH)) begin
          if (m_brun + 1 == BATT_CNT) begin m_blow <= !m_blow; m_brun <= 0; end
          else m_brun <= m_brun + 1;
        end else begin
          m_brun <= 0;
        end
      end
      if (en_steer && pwr_up) begin
        m_qrun <= (m_qrun < 100) ? m_qrun + 1 : m_qrun;
        m_norm <= (m_qrun >= NORM_QUAL);
      end else begin
        m_qrun <= 0;
        m_norm <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_ovr_spd",   ovr_spd,   m_ovr);
      check("model_batt_low",  batt_low,  m_blow);
      check("model_norm_mode", norm_mode, m_norm);
    end
  end

  // ---------------- battery vector table ----------------
  typedef struct {
    logic [11:0] sample;
    logic        exp_low;
  } batt_vec_t;

  batt_vec_t bvec [16];

  function automatic logic [11:0] pick_spd();
    case ($urandom_range(0, 7))
      0: return 12'd1536;
      1: return 12'd1537;
      2: return 12'h800;
      3: return -12'sd1537;
      4: return -12'sd1536;
      5: return 12'd0;
      default: return 12'($urandom);
    endcase
  endfunction

  function automatic logic [11:0] pick_batt();
    case ($urandom_range(0, 7))
      0: return 12'h7F0;
      1: return 12'h7FF;
      2: return 12'h800;
      3: return 12'h820;
      4: return 12'h83F;
      5: return 12'h840;
      6: return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    bvec[0]  = '{12'h7F0, 1'b0}; bvec[1]  = '{12'h7F0, 1'b0}; bvec[2]  = '{12'h7F0, 1'b0};
    bvec[3]  = '{12'h800, 1'b0};
    bvec[4]  = '{12'h7F0, 1'b0}; bvec[5]  = '{12'h7F0, 1'b0}; bvec[6]  = '{12'h7F0, 1'b0};
    bvec[7]  = '{12'h7F0, 1'b1};
    bvec[8]  = '{12'h820, 1'b1}; bvec[9]  = '{12'h820, 1'b1}; bvec[10] = '{12'h820, 1'b1};
    bvec[11] = '{12'h820, 1'b1};
    bvec[12] = '{12'h840, 1'b1}; bvec[13] = '{12'h840, 1'b1}; bvec[14] = '{12'h840, 1'b1};
    bvec[15] = '{12'h840, 1'b0};

    rst_n = 1'b0; pwr_up = 1'b0; en_steer = 1'b0; batt_vld = 1'b0;
    lft_spd = '0; rght_spd = '0; batt = 12'hFFF;
    #12;
    check("reset_ovr_spd",   ovr_spd,   1'b0);
    check("reset_batt_low",  batt_low,  1'b0);
    check("reset_norm_mode", norm_mode, 1'b0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // battery: low qualification, dropout, hysteresis band, recovery
    for (int i = 0; i < 16; i++) begin
      batt = bvec[i].sample; batt_vld = 1'b1;
      wait_edges(1);
      batt_vld = 1'b0;
      check($sformatf("batt_vec%0d", i), batt_low, bvec[i].exp_low);
      wait_edges(9);
    end

    // over-speed assert latency on the left wheel
    lft_spd = 12'd1537;
    wait_edges(SPD_HOLD - 1); check("ovr_1537_early", ovr_spd, 1'b0);
    wait_edges(1);            check("ovr_1537_rise",  ovr_spd, 1'b1);
    lft_spd = 12'd0;
    wait_edges(SPD_HOLD);     check("ovr_1537_fall",  ovr_spd, 1'b0);
    lft_spd = 12'd1536;
    wait_edges(SPD_HOLD + 100); check("ovr_1536_never", ovr_spd, 1'b0);
    lft_spd = 12'd0;

    // negative saturated magnitude, glitch tolerance on release
    rght_spd = 12'h800;
    wait_edges(SPD_HOLD - 1); check("ovr_neg_early", ovr_spd, 1'b0);
    wait_edges(1);            check("ovr_neg_rise",  ovr_spd, 1'b1);
    rght_spd = 12'd0;
    wait_edges(SPD_HOLD - 1); check("ovr_gap1023_hold", ovr_spd, 1'b1);
    rght_spd = 12'h800;
    wait_edges(5);            check("ovr_restore_hold", ovr_spd, 1'b1);
    rght_spd = 12'd0;
    wait_edges(SPD_HOLD - 1); check("ovr_gap_pre", ovr_spd, 1'b1);
    wait_edges(1);            check("ovr_gap1024_fall", ovr_spd, 1'b0);

    // norm mode qualification and dropout
    pwr_up = 1'b1; en_steer = 1'b1;
    wait_edges(NORM_QUAL);    check("norm_early", norm_mode, 1'b0);
    wait_edges(1);            check("norm_rise",  norm_mode, 1'b1);
    en_steer = 1'b0;
    wait_edges(1);            check("norm_drop",  norm_mode, 1'b0);
    en_steer = 1'b1;
    wait_edges(NORM_QUAL);    check("norm_requal_early", norm_mode, 1'b0);
    wait_edges(1);            check("norm_requal_rise",  norm_mode, 1'b1);

    // all alerts active, then asynchronous reset mid-cycle
    rght_spd = 12'h800;
    for (int i = 0; i < BATT_CNT; i++) begin
      batt = 12'h7F0; batt_vld = 1'b1;
      wait_edges(1);
      batt_vld = 1'b0;
      wait_edges(9);
    end
    wait_edges(SPD_HOLD);
    check("all_ovr",  ovr_spd,   1'b1);
    check("all_batt", batt_low,  1'b1);
    check("all_norm", norm_mode, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_ovr",  ovr_spd,   1'b0);
    check("async_batt", batt_low,  1'b0);
    check("async_norm", norm_mode, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_edges(NORM_QUAL);    check("post_rst_norm_early", norm_mode, 1'b0);
    wait_edges(1);            check("post_rst_norm_rise",  norm_mode, 1'b1);
    wait_edges(SPD_HOLD - NORM_QUAL - 2);
    check("post_rst_ovr_early", ovr_spd,  1'b0);
    check("post_rst_batt",      batt_low, 1'b0);
    wait_edges(1);            check("post_rst_ovr_rise", ovr_spd, 1'b1);

    // randomized segments, checked against the model every cycle
    for (int s = 0; s < 24; s++) begin
      logic [11:0] seg_batt;
      int          len;
      lft_spd  = pick_spd();
      rght_spd = pick_spd();
      seg_batt = pick_batt();
      pwr_up   = ($urandom_range(0, 3) != 0);
      en_steer = ($urandom_range(0, 3) != 0);
      len      = $urandom_range(1, 1300);
      for (int c = 0; c < len; c++) begin
        batt_vld = ($urandom_range(0, 3) == 0);
        batt     = ($urandom_range(0, 7) == 0) ? pick_batt() : seg_batt;
        if ($urandom_range(0, 63) == 0) en_steer = ~en_steer;
        if ($urandom_range(0, 255) == 0) rght_spd = pick_spd();
        wait_edges(1);
      end
    end
    batt_vld = 1'b0;
    wait_edges(2);
    chk_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
